// File: rtl/reorder_and_add.sv
// reorder_and_add: registered scatter-add; lanes data_in0..8 are summed into bucket index<i>, add_res<k+1> holds bucket k (clk, rst sync high)
module reorder_and_add #(
  parameter int DATA_W = 8,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [DATA_W-1:0] data_in4,
  input  logic [DATA_W-1:0] data_in5,
  input  logic [DATA_W-1:0] data_in6,
  input  logic [DATA_W-1:0] data_in7,
  input  logic [DATA_W-1:0] data_in8,
  input  logic [IDX_W-1:0]  index0,
  input  logic [IDX_W-1:0]  index1,
  input  logic [IDX_W-1:0]  index2,
  input  logic [IDX_W-1:0]  index3,
  input  logic [IDX_W-1:0]  index4,
  input  logic [IDX_W-1:0]  index5,
  input  logic [IDX_W-1:0]  index6,
  input  logic [IDX_W-1:0]  index7,
  input  logic [IDX_W-1:0]  index8,
  output logic [DATA_W-1:0] add_res1,
  output logic [DATA_W-1:0] add_res2,
  output logic [DATA_W-1:0] add_res3,
  output logic [DATA_W-1:0] add_res4,
  output logic [DATA_W-1:0] add_res5,
  output logic [DATA_W-1:0] add_res6,
  output logic [DATA_W-1:0] add_res7,
  output logic [DATA_W-1:0] add_res8,
  output logic [DATA_W-1:0] add_res9
);
  logic [DATA_W-1:0] d [9];
  logic [IDX_W-1:0]  x [9];
  logic [DATA_W-1:0] sum_d [9];
  logic [DATA_W-1:0] sum_q [9];
  assign d = '{data_in0, data_in1, data_in2, data_in3, data_in4, data_in5, data_in6, data_in7, data_in8};
  assign x = '{index0, index1, index2, index3, index4, index5, index6, index7, index8};
  always_comb begin
    sum_d = '{default: '0};
    for (int k = 0; k < 9; k++)
      for (int i = 0; i < 9; i++)
        sum_d[k] = sum_d[k] + ((x[i] == IDX_W'(k)) ? d[i] : '0);
  end
  always_ff @(posedge clk)
    if (rst) sum_q <= '{default: '0};
    else sum_q <= sum_d;
  assign add_res1 = sum_q[0];
  assign add_res2 = sum_q[1];
  assign add_res3 = sum_q[2];
  assign add_res4 = sum_q[3];
  assign add_res5 = sum_q[4];
  assign add_res6 = sum_q[5];
  assign add_res7 = sum_q[6];
  assign add_res8 = sum_q[7];
  assign add_res9 = sum_q[8];
endmodule

// File: tb/tb_reorder_and_add.sv
// tb_reorder_and_add: table vectors, reset/latency sequences and random stimulus against a scatter-add model
module tb_reorder_and_add;
  typedef struct {
    int d [9];
    int x [9];
    int e [9];
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  logic [7:0] d_a [9];
  logic [7:0] x_a [9];
  logic [7:0] r [9];
  int checks = 0;
  int errors = 0;
  vec_t tbl [6];
  always #5 clk = ~clk;
  reorder_and_add #(.DATA_W(8), .IDX_W(8)) dut (
    .clk(clk), .rst(rst),
    .data_in0(d_a[0]), .data_in1(d_a[1]), .data_in2(d_a[2]), .data_in3(d_a[3]), .data_in4(d_a[4]),
    .data_in5(d_a[5]), .data_in6(d_a[6]), .data_in7(d_a[7]), .data_in8(d_a[8]),
    .index0(x_a[0]), .index1(x_a[1]), .index2(x_a[2]), .index3(x_a[3]), .index4(x_a[4]),
    .index5(x_a[5]), .index6(x_a[6]), .index7(x_a[7]), .index8(x_a[8]),
    .add_res1(r[0]), .add_res2(r[1]), .add_res3(r[2]), .add_res4(r[3]), .add_res5(r[4]),
    .add_res6(r[5]), .add_res7(r[6]), .add_res8(r[7]), .add_res9(r[8])
  );
  function automatic void model(input int d [9], input int x [9], output int e [9]);
    e = '{default: 0};
    foreach (d[i]) if (x[i] < 9) e[x[i]] += d[i];
    foreach (e[k]) e[k] = e[k] % 256;
  endfunction
  task automatic chk(input string nm, input int e [9]);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (r[k] !== 8'(e[k])) begin
        errors++;
        $display("FAIL %s add_res%0d got %0d want %0d", nm, k + 1, r[k], e[k]);
      end
    end
  endtask
  task automatic step(input string nm, input int d [9], input int x [9], input logic rs, input int e [9]);
    for (int i = 0; i < 9; i++) begin
      d_a[i] = 8'(d[i]);
      x_a[i] = 8'(x[i]);
    end
    rst = rs;
    @(posedge clk);
    #1;
    chk(nm, e);
  endtask
  initial begin
    int z [9];
    int rd [9];
    int rx [9];
    int re [9];
    int q_d [4][9];
    int q_x [4][9];
    z = '{default: 0};
    tbl[0] = '{d: '{0, 2, 4, 8, 0, 0, 0, 0, 0}, x: '{0, 1, 2, 1, 1, 3, 0, 0, 0}, e: '{0, 10, 4, 0, 0, 0, 0, 0, 0}};
    tbl[1] = '{d: '{1, 2, 3, 4, 5, 6, 7, 8, 9}, x: '{8, 7, 6, 5, 4, 3, 2, 1, 0}, e: '{9, 8, 7, 6, 5, 4, 3, 2, 1}};
    tbl[2] = '{d: '{default: 100}, x: '{default: 0}, e: '{132, 0, 0, 0, 0, 0, 0, 0, 0}};
    tbl[3] = '{d: '{default: 255}, x: '{default: 4}, e: '{0, 0, 0, 0, 247, 0, 0, 0, 0}};
    tbl[4] = '{d: '{default: 5}, x: '{9, 255, 8, 8, 16, 0, 200, 9, 1}, e: '{5, 5, 0, 0, 0, 0, 0, 0, 10}};
    tbl[5] = '{d: '{default: 7}, x: '{default: 9}, e: '{default: 0}};
    step("reset1", tbl[1].d, tbl[1].x, 1, z);
    step("reset2", tbl[1].d, tbl[1].x, 1, z);
    step("reset_release", tbl[1].d, tbl[1].x, 0, tbl[1].e);
    foreach (tbl[t]) step($sformatf("table%0d", t), tbl[t].d, tbl[t].x, 0, tbl[t].e);
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 9; i++) begin
        q_d[c][i] = int'($urandom_range(255));
        q_x[c][i] = int'($urandom_range(10));
      end
    for (int c = 0; c < 4; c++) begin
      model(q_d[c], q_x[c], re);
      if (c == 2) step("b2b_rst", q_d[c], q_x[c], 1, z);
      else step($sformatf("b2b%0d", c), q_d[c], q_x[c], 0, re);
    end
    for (int n = 0; n < 300; n++) begin
      logic rs;
      for (int i = 0; i < 9; i++) begin
        rd[i] = int'($urandom_range(255));
        rx[i] = ($urandom_range(7) == 0) ? int'($urandom_range(255)) : int'($urandom_range(8));
      end
      rs = ($urandom_range(19) == 0);
      model(rd, rx, re);
      step("random", rd, rx, rs, rs ? z : re);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
